// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first,
// start/busy/done handshake with registered sum, carry/borrow and overflow.
module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s_bit, c_bit, last_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // The single full-adder cell.
  always_comb begin
    s_bit    = op_a[0] ^ op_b[0] ^ carry;
    c_bit    = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    last_bit = (count == LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values of the others.
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
          op_a  <= a;
          op_b  <= mode ? ~b : b;
          carry <= mode;
          count <= '0;
          res   <= '0;
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          res   <= {s_bit, res[WIDTH-1:1]};
          carry <= c_bit;
          count <= count + CW'(1);
          if (last_bit) begin
            sum      <= {s_bit, res[WIDTH-1:1]};
            cout     <= c_bit;
            // On the MSB edge, carry still holds the carry into bit WIDTH-1.
            overflow <= carry ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_n.sv
// Scoreboard bench for serial_addsub_n: WIDTH=8 directed vectors, plus
// WIDTH=2 (exhaustive) and WIDTH=16 instances checked against a model.
module tb_serial_addsub_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, mode8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, mode2, busy2, done2, cout2, ovf2;
  logic [1:0]  a2, b2, sum2;
  logic        start16, mode16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_addsub_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
  serial_addsub_n #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));
  serial_addsub_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q8[$], q2[$], q16[$];
  int checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic reference: unsigned carry/borrow and signed-range overflow.
  function automatic exp_t model(input int w, input logic m, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint mask, half, ux, uy, full, sx, sy, r;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ux    = longint'(x) & mask;
    uy    = longint'(y) & mask;
    full  = m ? ux + ((~uy) & mask) + 1 : ux + uy;
    sx    = (ux >= half) ? ux - (mask + 1) : ux;
    sy    = (uy >= half) ? uy - (mask + 1) : uy;
    r     = m ? sx - sy : sx + sy;
    e.sum  = 32'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
    e.ovf  = (r > half - 1) || (r < -half);
    e.due  = 0;
    return e;
  endfunction

  // Monitors: pop one expectation per done pulse; latency is checked by cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) check("done8_unexpected", done8, 0);
      else begin
        e = q8.pop_front();
        check("sum8", sum8, e.sum);
        check("cout8", cout8, e.cout);
        check("ovf8", ovf8, e.ovf);
        check("lat8", cyc, e.due);
        check("busy8_in_done", busy8, 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) check("done2_unexpected", done2, 0);
      else begin
        e = q2.pop_front();
        check("sum2", sum2, e.sum);
        check("cout2", cout2, e.cout);
        check("ovf2", ovf2, e.ovf);
        check("lat2", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) check("done16_unexpected", done16, 0);
      else begin
        e = q16.pop_front();
        check("sum16", sum16, e.sum);
        check("cout16", cout16, e.cout);
        check("ovf16", ovf16, e.ovf);
        check("lat16", cyc, e.due);
      end
    end
  end

  // Called at a negedge with dut8 idle; operands are scrambled after acceptance.
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.due = cyc + 1 + 8;
    q8.push_back(e);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; mode8 = ~m; a8 = ~x; b8 = ~y;
    n = 0;
    while (busy8 && n < 40) begin n++; @(negedge clk); end
    check("busy8_cycles", n, 9);
  endtask

  task automatic op2(input logic m, input logic [1:0] x, input logic [1:0] y);
    exp_t e;
    int   n;
    e = model(2, m, 32'(x), 32'(y));
    e.due = cyc + 1 + 2;
    q2.push_back(e);
    start2 = 1'b1; mode2 = m; a2 = x; b2 = y;
    @(negedge clk);
    start2 = 1'b0; a2 = ~x; b2 = ~y;
    n = 0;
    while (busy2 && n < 20) begin n++; @(negedge clk); end
    check("busy2_cycles", n, 3);
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   n;
    e = model(16, m, 32'(x), 32'(y));
    e.due = cyc + 1 + 16;
    q16.push_back(e);
    start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 1'b0; a16 = ~x; b16 = ~y;
    n = 0;
    while (busy16 && n < 60) begin n++; @(negedge clk); end
    check("busy16_cycles", n, 17);
  endtask

  logic [15:0] vec16 [6][2];

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0;
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    start2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0;
    start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    // Reset overrides start.
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_busy2", busy2, 0);
    check("rst_busy16", busy16, 0);
    start8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Add and subtract with hand-computed flags.
    op8(1'b0, 8'd100, 8'd27,  8'd127, 1'b0, 1'b0);
    op8(1'b0, 8'd100, 8'd100, 8'hC8,  1'b0, 1'b1);
    op8(1'b0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0);
    op8(1'b0, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1);
    op8(1'b1, 8'd5,   8'd7,   8'hFE,  1'b0, 1'b0);
    op8(1'b1, 8'h80,  8'h01,  8'h7F,  1'b1, 1'b1);
    op8(1'b1, 8'h3C,  8'h3C,  8'h00,  1'b1, 1'b0);
    op8(1'b1, 8'h00,  8'h80,  8'h80,  1'b0, 1'b1);

    // Handshake: starts during RUN and during DONE are ignored.
    e.sum = 32'd3; e.cout = 1'b0; e.ovf = 1'b0; e.due = cyc + 1 + 8;
    q8.push_back(e);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin n++; @(negedge clk); end
    check("hs_done_seen", done8, 1);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'hAA; b8 = 8'h11;
    @(negedge clk);
    check("hs_idle_after_done", busy8, 0);

    // start held high: the IDLE edge re-samples the new operands.
    a8 = 8'h90; b8 = 8'h90;
    e.sum = 32'h20; e.cout = 1'b1; e.ovf = 1'b1; e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    check("held_busy", busy8, 1);
    repeat (3) @(negedge clk);
    check("hold_sum", sum8, 3);
    check("hold_cout", cout8, 0);
    n = 0;
    while (!done8 && n < 20) begin n++; @(negedge clk); end
    check("held_done_seen", done8, 1);
    start8 = 1'b0;
    @(negedge clk);
    check("held_idle", busy8, 0);

    // Reset after four RUN edges abandons the operation.
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", busy8, 0);
    check("mrst_done", done8, 0);
    check("mrst_sum", sum8, 0);
    check("mrst_cout", cout8, 0);
    check("mrst_ovf", ovf8, 0);
    repeat (10) @(negedge clk);
    check("mrst_still_idle", busy8, 0);
    op8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // WIDTH=2: every operand pair in both modes.
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          op2(1'(m), 2'(x), 2'(y));

    // WIDTH=16: corner vectors in both modes.
    vec16[0] = '{16'h7FFF, 16'h0001};
    vec16[1] = '{16'hFFFF, 16'hFFFF};
    vec16[2] = '{16'h8000, 16'h0001};
    vec16[3] = '{16'h1234, 16'hABCD};
    vec16[4] = '{16'h0000, 16'h8000};
    vec16[5] = '{16'hC350, 16'hC350};
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 6; i++)
        op16(1'(m), vec16[i][0], vec16[i][1]);

    repeat (5) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q2_drained", q2.size(), 0);
    check("q16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub_n.md
Name: serial_addsub_n

Overview:
- Parametrised bit-serial N-bit adder/subtractor built around a single full-adder cell.
- Processes one bit per clock, LSB first, with a registered carry flip-flop.
- Uses a start/busy/done handshake.
- Area-cheap arithmetic unit for the adders/subtractors family; extends the combinational half/full adder cells to multi-bit, two-mode, clocked operation with unsigned carry/borrow and signed overflow flags.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress, including the done cycle
- done  output  1  one-cycle pulse; result outputs valid from this cycle on
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  add: carry out; sub: 1 = no borrow (a >= b unsigned), 0 = borrow
- overflow  output  1  signed two's-complement overflow

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, carry and bit counter are cleared.
  - Reset overrides start.
  - Reset mid-operation abandons the operation: no done pulse, outputs forced to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0.
    - At an edge with start=1: load opA=a, opB=(mode ? ~b : b), carry=mode, count=0, go RUN.
    - start=0: stay IDLE.
  - RUN: busy=1, done=0.
    - Each edge computes s = opA[0]^opB[0]^carry and updates carry = majority(opA[0], opB[0], carry).
    - opA and opB shift right by 1; s shifts into the MSB of the internal result register; count increments.
    - Keep the carry into bit WIDTH-1 for overflow.
    - On the edge processing bit WIDTH-1 (count=WIDTH-1):
      - sum <= completed result.
      - cout <= final carry.
      - overflow <= carry_into_msb XOR final carry.
      - Go DONE.
  - DONE: busy=1, done=1 for exactly one cycle; next edge goes IDLE unconditionally.
- Latency: with start sampled at edge k:
  - busy rises after edge k.
  - sum/cout/overflow update and done rises after edge k+WIDTH.
  - done falls and busy falls after edge k+WIDTH+1.
  - New start accepted at edge k+WIDTH+1 at the earliest. Throughput: one operation per WIDTH+1 cycles.
- start, mode, a, b are ignored while busy=1, including the DONE cycle. Operands may change freely after acceptance.
- sum, cout, overflow are registered. They hold their last value until the next operation completes; they do not toggle during RUN.
- Arithmetic is modulo 2^WIDTH, with no saturation.
  - Subtraction is a + ~b + 1 via the carry-in, so cout is the inverted borrow.
- start held high continuously: back-to-back operations, each re-sampling the operands at the IDLE edge.

Test Plan (WIDTH=8 unless stated):
1. Add, no flags: start with mode=0, a=100, b=27 -> after 8 edges done=1 for one cycle, sum=127, cout=0, overflow=0; busy high for exactly 9 cycles.
2. Add, signed overflow and carry wrap:
   - a=100, b=100 -> sum=0xC8, cout=0, overflow=1.
   - a=0xFF, b=0x01 -> sum=0x00, cout=1, overflow=0.
3. Subtract, borrow and overflow:
   - mode=1, a=5, b=7 -> sum=0xFE, cout=0, overflow=0.
   - a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
   - a=b=0x3C -> sum=0, cout=1, overflow=0.
4. Handshake:
   - Pulse start (a=1, b=2); assert start with a=0xAA during RUN and again in the DONE cycle -> both ignored, result sum=3.
   - start held high -> second operation begins at the edge after done; outputs hold 3 until it completes.
5. Reset mid-operation: assert rst_n=0 after 4 RUN edges for one cycle -> busy=0, sum=0, cout=0, overflow=0, no done pulse; a fresh start afterwards completes correctly.
6. Parametric: WIDTH=2 and WIDTH=16 with random operands across both modes against a reference model -> sum, cout and overflow match; done occurs exactly WIDTH edges after start.
